// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared memory port: fetch (0) and LSU (1).
// State | meaning: IDLE = port free, arbitrate on req; ACCESS = winner owns port, wait mem_ready or watchdog.
module mem_port_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic we1,
    output logic gnt0,
    output logic gnt1,
    output logic done0,
    output logic done1,
    output logic err0,
    output logic err1,
    output logic mem_sel,
    output logic mem_req,
    output logic mem_we,
    input  logic mem_ready
);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last;
    logic               r_gnt0, r_gnt1, r_done0, r_done1, r_err0, r_err1;
    logic               r_sel, r_req, r_we;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_last_nxt;
    logic               w_gnt0_nxt, w_gnt1_nxt, w_done0_nxt, w_done1_nxt;
    logic               w_err0_nxt, w_err1_nxt;
    logic               w_sel_nxt, w_req_nxt, w_we_nxt;
    logic               w_any_req, w_winner, w_timeout;

    assign w_any_req = req0 | req1;
    // On a tie the round-robin mode hands the port to whoever did not win last.
    assign w_winner  = (req0 && req1) ? ((ROUND_ROBIN != 0) ? ~r_last : 1'b1) : req1;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            r_sel   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_gnt0  <= w_gnt0_nxt;
            r_gnt1  <= w_gnt1_nxt;
            r_done0 <= w_done0_nxt;
            r_done1 <= w_done1_nxt;
            r_err0  <= w_err0_nxt;
            r_err1  <= w_err1_nxt;
            r_sel   <= w_sel_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req) w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (mem_ready || w_timeout) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_gnt0_nxt  = r_gnt0;
        w_gnt1_nxt  = r_gnt1;
        w_done0_nxt = 1'b0;
        w_done1_nxt = 1'b0;
        w_err0_nxt  = 1'b0;
        w_err1_nxt  = 1'b0;
        w_sel_nxt   = r_sel;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_sel_nxt  = w_winner;
                    w_req_nxt  = 1'b1;
                    w_gnt0_nxt = ~w_winner;
                    w_gnt1_nxt = w_winner;
                    w_we_nxt   = w_winner & we1;
                    w_cnt_nxt  = '0;
                    w_last_nxt = w_winner;
                end else begin
                    w_req_nxt  = 1'b0;
                    w_gnt0_nxt = 1'b0;
                    w_gnt1_nxt = 1'b0;
                    w_we_nxt   = 1'b0;
                end
            end
            ST_ACCESS: begin
                // mem_ready takes precedence over a watchdog expiry on the same edge.
                if (mem_ready || w_timeout) begin
                    w_req_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_gnt0_nxt  = 1'b0;
                    w_gnt1_nxt  = 1'b0;
                    w_done0_nxt = mem_ready & ~r_sel;
                    w_done1_nxt = mem_ready & r_sel;
                    w_err0_nxt  = ~mem_ready & ~r_sel;
                    w_err1_nxt  = ~mem_ready & r_sel;
                end else if (TIMEOUT != 0) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign done0   = r_done0;
    assign done1   = r_done1;
    assign err0    = r_err0;
    assign err1    = r_err1;
    assign mem_sel = r_sel;
    assign mem_req = r_req;
    assign mem_we  = r_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected completions, monitors pop on done/err pulses.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic       err;
        logic       who;
        logic [7:0] len;
        logic       we;
        logic       sel;
        logic       stable;
        logic       onehot;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic a_req0 = 0, a_req1 = 0, a_we1 = 0, a_rdy = 0;
    logic a_gnt0, a_gnt1, a_done0, a_done1, a_err0, a_err1, a_sel, a_mreq, a_mwe;
    logic b_req0 = 0, b_req1 = 0, b_we1 = 0, b_rdy = 0;
    logic b_gnt0, b_gnt1, b_done0, b_done1, b_err0, b_err1, b_sel, b_mreq, b_mwe;

    mem_port_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req0(a_req0), .req1(a_req1), .we1(a_we1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .done0(a_done0), .done1(a_done1),
        .err0(a_err0), .err1(a_err1), .mem_sel(a_sel), .mem_req(a_mreq),
        .mem_we(a_mwe), .mem_ready(a_rdy));

    mem_port_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(16), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .req0(b_req0), .req1(b_req1), .we1(b_we1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
        .err0(b_err0), .err1(b_err1), .mem_sel(b_sel), .mem_req(b_mreq),
        .mem_we(b_mwe), .mem_ready(b_rdy));

    int n_pass = 0;
    int n_total = 0;
    ev_t qa[$];
    ev_t qb[$];
    int b_gnt0_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic ev_t mk(input logic err, input logic who, input int len, input logic we);
        ev_t e;
        e.err = err; e.who = who; e.len = 8'(len); e.we = we;
        e.sel = who; e.stable = 1'b1; e.onehot = 1'b1;
        return e;
    endfunction

    // Monitor for the round-robin instance
    logic [7:0] a_len = 0;
    logic a_we_or, a_we_and, a_sel_or, a_sel_and;
    always @(negedge clk) begin
        ev_t act, exp;
        if (!rst_n) begin
            a_len = 0;
        end else begin
            if (a_mreq) begin
                if (a_len == 0) begin
                    a_we_or = a_mwe; a_we_and = a_mwe; a_sel_or = a_sel; a_sel_and = a_sel;
                end else begin
                    a_we_or |= a_mwe; a_we_and &= a_mwe; a_sel_or |= a_sel; a_sel_and &= a_sel;
                end
                a_len++;
            end
            if (a_done0 | a_done1 | a_err0 | a_err1) begin
                act.err = a_err0 | a_err1;
                act.who = a_done1 | a_err1;
                act.len = a_len;
                act.we = a_we_or;
                act.sel = a_sel_or;
                act.stable = (a_we_or == a_we_and) && (a_sel_or == a_sel_and);
                act.onehot = $onehot({a_done0, a_done1, a_err0, a_err1}) && !(a_gnt0 && a_gnt1);
                if (qa.size() == 0) chk("a_unexpected_event", 32'(act), 32'h0);
                else begin
                    exp = qa.pop_front();
                    chk("a_event", 32'(act), 32'(exp));
                end
                a_len = 0;
            end
        end
    end

    // Monitor for the fixed-priority instance
    logic [7:0] b_len = 0;
    logic b_we_or, b_we_and, b_sel_or, b_sel_and;
    always @(negedge clk) begin
        ev_t act, exp;
        if (!rst_n) begin
            b_len = 0;
        end else begin
            if (b_gnt0) b_gnt0_cycles++;
            if (b_mreq) begin
                if (b_len == 0) begin
                    b_we_or = b_mwe; b_we_and = b_mwe; b_sel_or = b_sel; b_sel_and = b_sel;
                end else begin
                    b_we_or |= b_mwe; b_we_and &= b_mwe; b_sel_or |= b_sel; b_sel_and &= b_sel;
                end
                b_len++;
            end
            if (b_done0 | b_done1 | b_err0 | b_err1) begin
                act.err = b_err0 | b_err1;
                act.who = b_done1 | b_err1;
                act.len = b_len;
                act.we = b_we_or;
                act.sel = b_sel_or;
                act.stable = (b_we_or == b_we_and) && (b_sel_or == b_sel_and);
                act.onehot = $onehot({b_done0, b_done1, b_err0, b_err1}) && !(b_gnt0 && b_gnt1);
                if (qb.size() == 0) chk("b_unexpected_event", 32'(act), 32'h0);
                else begin
                    exp = qb.pop_front();
                    chk("b_event", 32'(act), 32'(exp));
                end
                b_len = 0;
            end
        end
    end

    // Single transaction on instance A: ready after nwait low-ready ACCESS edges.
    task automatic a_xfer(input logic who, input logic we, input int nwait);
        logic got;
        qa.push_back(mk(1'b0, who, nwait + 1, who & we));
        if (who) begin a_req1 = 1; a_we1 = we; end else a_req0 = 1;
        a_rdy = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = who ? a_gnt1 : a_gnt0;
        end
        chk("a_grant_wait", 32'(got), 32'd1);
        repeat (nwait) @(negedge clk);
        a_rdy = 1;
        @(negedge clk);
        a_rdy = 0; a_req0 = 0; a_req1 = 0; a_we1 = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic ended;
        repeat (3) @(negedge clk);
        chk("a_reset_outputs", 32'({a_gnt0, a_gnt1, a_done0, a_done1, a_err0, a_err1, a_sel, a_mreq, a_mwe}), 32'h0);
        chk("b_reset_outputs", 32'({b_gnt0, b_gnt1, b_done0, b_done1, b_err0, b_err1, b_sel, b_mreq, b_mwe}), 32'h0);
        rst_n = 1;
        @(negedge clk);
        chk("a_idle_after_release", 32'({a_gnt0, a_gnt1, a_mreq, a_sel}), 32'h0);

        // Continuous tie with ready every ACCESS cycle on both instances
        for (int i = 0; i < 4; i++) begin
            qa.push_back(mk(1'b0, 1'(i % 2), 1, 1'b0));
            qb.push_back(mk(1'b0, 1'b1, 1, 1'b0));
        end
        a_req0 = 1; a_req1 = 1; a_rdy = 1;
        b_req0 = 1; b_req1 = 1; b_rdy = 1;
        repeat (8) @(negedge clk);
        a_req0 = 0; a_req1 = 0; a_rdy = 0;
        b_req0 = 0; b_req1 = 0; b_rdy = 0;
        repeat (2) @(negedge clk);

        a_xfer(1'b0, 1'b0, 2);
        @(negedge clk);

        // Watchdog abort for requester 1 with write
        qa.push_back(mk(1'b1, 1'b1, 16, 1'b1));
        a_req1 = 1; a_we1 = 1; a_rdy = 0;
        ended = 0;
        for (int i = 0; i < 40 && !ended; i++) begin
            @(negedge clk);
            ended = a_err1 | a_done1;
        end
        chk("a_timeout_wait", 32'(ended), 32'd1);
        a_req1 = 0; a_we1 = 0;
        @(negedge clk);

        // ready on the same edge the watchdog would fire
        a_xfer(1'b1, 1'b1, 15);
        @(negedge clk);

        // Asynchronous reset in the middle of an LSU access
        a_req1 = 1; a_we1 = 1; a_rdy = 0;
        ended = 0;
        for (int i = 0; i < 20 && !ended; i++) begin
            @(negedge clk);
            ended = a_gnt1;
        end
        chk("a_grant_before_reset", 32'(ended), 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 0;
        a_req1 = 0; a_we1 = 0;
        #1;
        chk("a_reset_mid_mem_req", 32'(a_mreq), 32'd0);
        chk("a_reset_mid_gnt1", 32'(a_gnt1), 32'd0);
        chk("a_reset_mid_sel", 32'(a_sel), 32'd0);
        chk("a_reset_mid_pulses", 32'({a_done0, a_done1, a_err0, a_err1, a_mwe}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        a_xfer(1'b0, 1'b0, 1);

        repeat (3) @(negedge clk);
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        chk("b_gnt0_starved", 32'(b_gnt0_cycles), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
